sdram_line_sequencer: RTL and testbench

//  Cache-miss line sequencer between the cache controller and the byte-wide SDRAM model.
//  Per request, optionally writes back a dirty victim line, then fills a LINE_BYTES line.

---
 rtl/sdram_seq_pkg.sv | 26 ++
 rtl/sdram_line_sequencer_line_assembler.sv | 44 ++++
 rtl/sdram_line_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_sdram_line_sequencer.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_seq_pkg.sv
// sdram_seq_pkg
//   Shared definitions for the SDRAM cache-line sequencer:
//   - seq_state_t : sequencer FSM states
//   - DEF_ADDR_W / DEF_LINE_BYTES : default geometry
//   - line_base() : clears the byte-in-line bits of an address
package sdram_seq_pkg;

   localparam int unsigned DEF_ADDR_W     = 16;
   localparam int unsigned DEF_LINE_BYTES = 4;

   typedef enum logic [2:0] {
      IDLE,
      WB,
      RD,
      RD_LAST,
      DONE
   } seq_state_t;

   // line_bytes must be a power of two, so masking with ~(line_bytes-1)
   // yields the first byte of the line.
   function automatic logic [31:0] line_base(input logic [31:0] addr,
                                             input int unsigned line_bytes = DEF_LINE_BYTES);
      return addr & ~(line_bytes - 1);
   endfunction

endpackage

// File: rtl/sdram_line_sequencer_line_assembler.sv
// line_assembler
//   Byte-indexed capture register used to build a cache line from the
//   byte-wide SDRAM read data.
// Ports
//   clk      in   clock, rising edge
//   rst_i    in   synchronous active-high reset, clears the line
//   clear_i  in   synchronous clear of the whole line
//   load_i   in   write byte_i into byte lane idx_i
//   idx_i    in   byte lane to load
//   byte_i   in   byte to capture
//   line_o   out  assembled line, byte i at [8*i +: 8]
module line_assembler
   import sdram_seq_pkg::*;
#(
   parameter  int unsigned LINE_BYTES = DEF_LINE_BYTES,
   localparam int unsigned IDX_W      = $clog2(LINE_BYTES)
) (
   input  logic                    clk,
   input  logic                    rst_i,
   input  logic                    clear_i,
   input  logic                    load_i,
   input  logic [IDX_W-1:0]        idx_i,
   input  logic [7:0]              byte_i,
   output logic [8*LINE_BYTES-1:0] line_o
);

   genvar gi;
   generate
      for (gi = 0; gi < LINE_BYTES; gi++) begin : g_byte
         logic [7:0] byte_q;

         always_ff @(posedge clk) begin
            if (rst_i || clear_i) begin
               byte_q <= '0;
            end else if (load_i && (idx_i == IDX_W'(gi))) begin
               byte_q <= byte_i;
            end
         end

         assign line_o[8*gi +: 8] = byte_q;
      end
   endgenerate

endmodule

// File: rtl/sdram_line_sequencer.sv
// sdram_line_sequencer
//   Cache-miss line sequencer between the cache controller and a byte-wide
//   SDRAM model. Per request it optionally writes back a dirty victim line,
//   then reads a LINE_BYTES line, one memory access per cycle, and presents
//   the assembled line on fill_data together with a one-cycle done pulse.
//
// Configuration macro
//   SDRAM_SEQ_WRITEBACK_EN : when defined, the WB state and victim datapath
//                            exist and req_wb is honoured. When undefined,
//                            req_wb / wb_addr / wb_data are ignored and every
//                            request is fill-only.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   req        in   request valid (accepted when req && req_ready)
//   req_ready  out  high only in IDLE
//   fill_addr  in   line to fill (byte-in-line bits ignored)
//   req_wb     in   write back victim line before the fill
//   wb_addr    in   victim line address (byte-in-line bits ignored)
//   wb_data    in   victim line, byte i at [8*i +: 8]
//   busy       out  sequencer not idle
//   done       out  one-cycle pulse, fill_data valid
//   fill_data  out  filled line, byte i = mem[base+i]
//   mem_add    out  SDRAM byte address
//   mem_din    out  SDRAM write data
//   mem_wr_rd  out  1 = write, 0 = read
//   mem_strb   out  SDRAM access strobe
//   mem_dout   in   SDRAM read data, valid the cycle after a read strobe
module sdram_line_sequencer
   import sdram_seq_pkg::*;
#(
   parameter int unsigned ADDR_W     = DEF_ADDR_W,
   parameter int unsigned LINE_BYTES = DEF_LINE_BYTES
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req,
   output logic                    req_ready,
   input  logic [ADDR_W-1:0]       fill_addr,
   input  logic                    req_wb,
   input  logic [ADDR_W-1:0]       wb_addr,
   input  logic [8*LINE_BYTES-1:0] wb_data,
   output logic                    busy,
   output logic                    done,
   output logic [8*LINE_BYTES-1:0] fill_data,
   output logic [ADDR_W-1:0]       mem_add,
   output logic [7:0]              mem_din,
   output logic                    mem_wr_rd,
   output logic                    mem_strb,
   input  logic [7:0]              mem_dout
);

   localparam int unsigned     CNT_W    = $clog2(LINE_BYTES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_BYTES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   seq_state_t        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] fill_base_q, fill_base_d;
   logic [ADDR_W-1:0] mem_add_q, mem_add_d;
   logic [7:0]        mem_din_q, mem_din_d;
   logic              mem_strb_q, mem_strb_d;
   logic              mem_wr_rd_q, mem_wr_rd_d;
   logic              done_q, done_d;

   logic              asm_load;
   logic              asm_clear;
   logic [CNT_W-1:0]  asm_idx;

`ifdef SDRAM_SEQ_WRITEBACK_EN
   logic [ADDR_W-1:0]       wb_base_q, wb_base_d;
   logic [8*LINE_BYTES-1:0] wb_data_q, wb_data_d;
`else
   // Victim inputs have no consumer in a fill-only build.
   logic unused_wb;
   assign unused_wb = ^{req_wb, wb_addr, wb_data};
`endif

   // ------------------------------------------------------------------
   // Next-state logic. Memory pin values are computed from the *next*
   // state so the pins themselves come straight from flops.
   // ------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      fill_base_d = fill_base_q;
`ifdef SDRAM_SEQ_WRITEBACK_EN
      wb_base_d   = wb_base_q;
      wb_data_d   = wb_data_q;
`endif
      asm_load    = 1'b0;
      asm_clear   = 1'b0;
      // Read data lags the strobe by one cycle, so byte i-1 arrives while
      // the counter shows i.
      asm_idx     = cnt_q - CNT_ONE;

      case (state_q)
         IDLE: begin
            if (req) begin
               cnt_d       = '0;
               asm_clear   = 1'b1;
               fill_base_d = ADDR_W'(line_base(32'(fill_addr), LINE_BYTES));
`ifdef SDRAM_SEQ_WRITEBACK_EN
               wb_base_d   = ADDR_W'(line_base(32'(wb_addr), LINE_BYTES));
               wb_data_d   = wb_data;
               state_d     = req_wb ? WB : RD;
`else
               state_d     = RD;
`endif
            end
         end
`ifdef SDRAM_SEQ_WRITEBACK_EN
         WB: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = RD;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
`endif
         RD: begin
            asm_load = (cnt_q != '0);
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = RD_LAST;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         RD_LAST: begin
            asm_load = 1'b1;
            asm_idx  = CNT_LAST;
            state_d  = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Memory pins: address and write data hold when not strobing.
      mem_strb_d  = 1'b0;
      mem_wr_rd_d = 1'b0;
      mem_add_d   = mem_add_q;
      mem_din_d   = mem_din_q;
      done_d      = (state_d == DONE);

      // Bases are line-aligned, so OR-ing in the counter never carries.
      if (state_d == RD) begin
         mem_strb_d = 1'b1;
         mem_add_d  = fill_base_d | ADDR_W'(cnt_d);
      end
`ifdef SDRAM_SEQ_WRITEBACK_EN
      if (state_d == WB) begin
         mem_strb_d  = 1'b1;
         mem_wr_rd_d = 1'b1;
         mem_add_d   = wb_base_d | ADDR_W'(cnt_d);
         mem_din_d   = wb_data_d[{cnt_d, 3'b000} +: 8];
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         fill_base_q <= '0;
         mem_add_q   <= '0;
         mem_din_q   <= '0;
         mem_strb_q  <= 1'b0;
         mem_wr_rd_q <= 1'b0;
         done_q      <= 1'b0;
`ifdef SDRAM_SEQ_WRITEBACK_EN
         wb_base_q   <= '0;
         wb_data_q   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         fill_base_q <= fill_base_d;
         mem_add_q   <= mem_add_d;
         mem_din_q   <= mem_din_d;
         mem_strb_q  <= mem_strb_d;
         mem_wr_rd_q <= mem_wr_rd_d;
         done_q      <= done_d;
`ifdef SDRAM_SEQ_WRITEBACK_EN
         wb_base_q   <= wb_base_d;
         wb_data_q   <= wb_data_d;
`endif
      end
   end

   line_assembler #(
      .LINE_BYTES (LINE_BYTES)
   ) u_line_assembler (
      .clk     (clk),
      .rst_i   (rst),
      .clear_i (asm_clear),
      .load_i  (asm_load),
      .idx_i   (asm_idx),
      .byte_i  (mem_dout),
      .line_o  (fill_data)
   );

   assign req_ready = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign mem_add   = mem_add_q;
   assign mem_din   = mem_din_q;
   assign mem_strb  = mem_strb_q;
   assign mem_wr_rd = mem_wr_rd_q;

endmodule

// File: tb/tb_sdram_line_sequencer.sv
`timescale 1ns/1ps
module tb_sdram_line_sequencer;

   localparam int AW = 16;
   localparam int LB = 4;
`ifdef SDRAM_SEQ_WRITEBACK_EN
   localparam bit WB_EN = 1'b1;
`else
   localparam bit WB_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          req;
   logic          req_ready;
   logic [AW-1:0] fill_addr;
   logic          req_wb;
   logic [AW-1:0] wb_addr;
   logic [31:0]   wb_data;
   logic          busy;
   logic          done;
   logic [31:0]   fill_data;
   logic [AW-1:0] mem_add;
   logic [7:0]    mem_din;
   logic          mem_wr_rd;
   logic          mem_strb;
   logic [7:0]    mem_dout;

   always #5 clk = ~clk;

   sdram_line_sequencer #(
      .ADDR_W     (AW),
      .LINE_BYTES (LB)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_ready (req_ready),
      .fill_addr (fill_addr),
      .req_wb    (req_wb),
      .wb_addr   (wb_addr),
      .wb_data   (wb_data),
      .busy      (busy),
      .done      (done),
      .fill_data (fill_data),
      .mem_add   (mem_add),
      .mem_din   (mem_din),
      .mem_wr_rd (mem_wr_rd),
      .mem_strb  (mem_strb),
      .mem_dout  (mem_dout)
   );

   // Byte-wide SDRAM model: write on strobe, read data one cycle later.
   logic [7:0] sdram [0:65535];
   initial begin
      for (int i = 0; i < 65536; i++) sdram[i] = i[7:0];
      mem_dout = 8'h00;
      forever begin
         @(posedge clk);
         if (mem_strb) begin
            if (mem_wr_rd) sdram[mem_add] = mem_din;
            else           mem_dout <= sdram[mem_add];
         end
      end
   end

   // One observed/expected cycle after an accept edge.
   typedef struct packed {
      logic        strb;
      logic        wr;
      logic [15:0] add;
      logic [7:0]  din;   // only meaningful on write strobes, else 0
      logic        done;
      logic        ready;
      logic        busy;
      logic [31:0] fill;  // only meaningful while done, else 0
   } cyc_t;

   int         checks   = 0;
   int         failures = 0;
   logic [7:0] ref_mem [0:65535];
   cyc_t       exp_q[$];
   cyc_t       obs_q[$];
   bit         timed_out;

   function automatic string fmt(input cyc_t c);
      return $sformatf("strb=%b wr=%b add=%h din=%h done=%b rdy=%b busy=%b fill=%h",
                       c.strb, c.wr, c.add, c.din, c.done, c.ready, c.busy, c.fill);
   endfunction

   // Reference: a request is LB writes (if write-back), LB reads, a quiet
   // cycle, a done cycle, then idle. The scoreboard memory applies the
   // victim writes before the fill reads it.
   function automatic void build_expected(input logic [15:0] fa, input logic rwb,
                                          input logic [15:0] wa, input logic [31:0] wd);
      int          nwb;
      int          fb;
      int          wbb;
      logic [31:0] line;
      cyc_t        e;
      nwb = (WB_EN && rwb) ? LB : 0;
      fb  = int'(fa) & ~(LB - 1);
      wbb = int'(wa) & ~(LB - 1);
      exp_q.delete();
      for (int i = 0; i < nwb; i++) begin
         e = '0; e.strb = 1'b1; e.wr = 1'b1; e.add = 16'(wbb + i);
         e.din = wd[8*i +: 8]; e.busy = 1'b1;
         exp_q.push_back(e);
         ref_mem[wbb + i] = wd[8*i +: 8];
      end
      for (int i = 0; i < LB; i++) begin
         e = '0; e.strb = 1'b1; e.add = 16'(fb + i); e.busy = 1'b1;
         exp_q.push_back(e);
      end
      for (int i = 0; i < LB; i++) line[8*i +: 8] = ref_mem[fb + i];
      e = '0; e.add = 16'(fb + LB - 1); e.busy = 1'b1;
      exp_q.push_back(e);
      e.done = 1'b1; e.fill = line;
      exp_q.push_back(e);
      e = '0; e.add = 16'(fb + LB - 1); e.ready = 1'b1;
      exp_q.push_back(e);
   endfunction

   // Drives one request and records exp_q.size() cycles after the accept edge.
   task automatic run_txn(input logic [15:0] fa, input logic rwb,
                          input logic [15:0] wa, input logic [31:0] wd);
      cyc_t o;
      int   n;
      obs_q.delete();
      timed_out = 1'b0;
      req = 1'b1; fill_addr = fa; req_wb = rwb; wb_addr = wa; wb_data = wd;
      n = 0;
      while (req_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (req_ready !== 1'b1) begin
         timed_out = 1'b1;
         req = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      // Inputs are free to change once accepted.
      req = 1'b0; fill_addr = 16'($urandom); req_wb = 1'($urandom);
      wb_addr = 16'($urandom); wb_data = $urandom;
      repeat (exp_q.size()) begin
         @(negedge clk);
         o = '0;
         o.strb  = mem_strb;
         o.wr    = mem_wr_rd;
         o.add   = mem_add;
         o.din   = (mem_strb && mem_wr_rd) ? mem_din : 8'h00;
         o.done  = done;
         o.ready = req_ready;
         o.busy  = busy;
         o.fill  = done ? fill_data : 32'h0;
         obs_q.push_back(o);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; req = 1'b0; fill_addr = '0; req_wb = 1'b0; wb_addr = '0; wb_data = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({req_ready, busy, done} !== 3'b100) begin
         failures++;
         $display("FAIL reset_status: rdy/busy/done=%b required 100", {req_ready, busy, done});
      end
      checks++;
      if ({mem_strb, mem_wr_rd, mem_add, mem_din} !== 26'h0) begin
         failures++;
         $display("FAIL reset_mem_pins: strb=%b wr=%b add=%h din=%h required all 0",
                  mem_strb, mem_wr_rd, mem_add, mem_din);
      end
      checks++;
      if (fill_data !== 32'h0) begin
         failures++;
         $display("FAIL reset_fill_data: got %h required 00000000", fill_data);
      end
      rst = 1'b0;
      @(negedge clk);
      $display("test_reset done");
   endtask

   task automatic test_fill_aligned();
      build_expected(16'h1234, 1'b0, 16'h0, 32'h0);
      run_txn(16'h1234, 1'b0, 16'h0, 32'h0);
      checks++;
      if (timed_out) begin failures++; $display("FAIL fill_aligned_accept: req_ready=%b required 1", req_ready); end
      foreach (exp_q[k]) begin
         checks++;
         if (obs_q[k] !== exp_q[k]) begin
            failures++;
            $display("FAIL fill_aligned cycle %0d: got %s required %s", k + 1, fmt(obs_q[k]), fmt(exp_q[k]));
         end
      end
      checks++;
      if (obs_q[5].fill !== 32'h37363534) begin
         failures++;
         $display("FAIL fill_aligned_data: got %h required 37363534", obs_q[5].fill);
      end
      $display("test_fill_aligned: fill 0x1234 -> %h", obs_q[5].fill);
   endtask

   task automatic test_fill_unaligned();
      build_expected(16'h1236, 1'b0, 16'h0, 32'h0);
      run_txn(16'h1236, 1'b0, 16'h0, 32'h0);
      checks++;
      if (timed_out) begin failures++; $display("FAIL fill_unaligned_accept: req_ready=%b required 1", req_ready); end
      foreach (exp_q[k]) begin
         checks++;
         if (obs_q[k] !== exp_q[k]) begin
            failures++;
            $display("FAIL fill_unaligned cycle %0d: got %s required %s", k + 1, fmt(obs_q[k]), fmt(exp_q[k]));
         end
      end
      checks++;
      if (obs_q[0].add !== 16'h1234) begin
         failures++;
         $display("FAIL fill_unaligned_first_add: got %h required 1234", obs_q[0].add);
      end
      $display("test_fill_unaligned: fill 0x1236 -> %h", obs_q[5].fill);
   endtask

   task automatic test_writeback();
      int want_done;
      int got_done;
      want_done = WB_EN ? 2*LB + 2 : LB + 2;
      build_expected(16'h0040, 1'b1, 16'h0040, 32'hDDCCBBAA);
      run_txn(16'h0040, 1'b1, 16'h0040, 32'hDDCCBBAA);
      checks++;
      if (timed_out) begin failures++; $display("FAIL writeback_accept: req_ready=%b required 1", req_ready); end
      got_done = -1;
      foreach (exp_q[k]) begin
         checks++;
         if (obs_q[k] !== exp_q[k]) begin
            failures++;
            $display("FAIL writeback cycle %0d: got %s required %s", k + 1, fmt(obs_q[k]), fmt(exp_q[k]));
         end
         if (obs_q[k].done === 1'b1 && got_done < 0) got_done = k + 1;
      end
      checks++;
      if (got_done != want_done) begin
         failures++;
         $display("FAIL writeback_latency: done in cycle %0d required %0d", got_done, want_done);
      end
      $display("test_writeback: wb_en=%0d done cycle %0d", WB_EN, got_done);
   endtask

   task automatic test_reset_mid();
      bit saw_done;
      req = 1'b1; fill_addr = 16'h2000; req_wb = 1'b0;
      @(posedge clk);
      #1 req = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;                       // high during cycle 3 of RD
      @(negedge clk);
      checks++;
      if ({mem_strb, req_ready, busy, done} !== 4'b0100) begin
         failures++;
         $display("FAIL reset_mid_status: strb/rdy/busy/done=%b required 0100",
                  {mem_strb, req_ready, busy, done});
      end
      checks++;
      if (fill_data !== 32'h0) begin
         failures++;
         $display("FAIL reset_mid_fill: got %h required 00000000", fill_data);
      end
      rst = 1'b0;
      saw_done = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (done === 1'b1 || mem_strb === 1'b1) saw_done = 1'b1;
      end
      checks++;
      if (saw_done) begin
         failures++;
         $display("FAIL reset_mid_quiet: done or strobe seen after reset, required none");
      end
      $display("test_reset_mid: aborted fill 0x2000");
   endtask

   task automatic test_back_to_back();
      int          d1, d2;
      logic [31:0] f1, f2, hold7;
      logic        rdy6, rdy7;
      d1 = -1; d2 = -1; f1 = '0; f2 = '0; hold7 = '0; rdy6 = 1'b1; rdy7 = 1'b0;
      req = 1'b1; fill_addr = 16'h0000; req_wb = 1'b0;
      @(posedge clk);
      #1 fill_addr = 16'h0100;          // req stays high
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            if (d1 < 0) begin d1 = c; f1 = fill_data; end
            else if (d2 < 0) begin d2 = c; f2 = fill_data; end
         end
         if (c == 6) rdy6 = req_ready;
         if (c == 7) begin rdy7 = req_ready; hold7 = fill_data; end
         if (c == 8) req = 1'b0;
      end
      checks++;
      if (d1 != 6 || f1 !== 32'h03020100) begin
         failures++;
         $display("FAIL b2b_first: done cycle %0d data %h required 6 03020100", d1, f1);
      end
      checks++;
      if (rdy6 !== 1'b0 || rdy7 !== 1'b1) begin
         failures++;
         $display("FAIL b2b_ready: rdy in cycles 6/7=%b%b required 01", rdy6, rdy7);
      end
      checks++;
      if (hold7 !== 32'h03020100) begin
         failures++;
         $display("FAIL b2b_hold: fill_data after done %h required 03020100", hold7);
      end
      checks++;
      if (d2 != 13 || f2 !== 32'h03020100) begin
         failures++;
         $display("FAIL b2b_second: done cycle %0d data %h required 13 03020100", d2, f2);
      end
      $display("test_back_to_back: done cycles %0d and %0d", d1, d2);
   endtask

   task automatic test_wb_flag();
      int          writes;
      logic [31:0] wd;
      wd = $urandom;
      build_expected(16'h0300, 1'b1, 16'h0080, wd);
      run_txn(16'h0300, 1'b1, 16'h0080, wd);
      checks++;
      if (timed_out) begin failures++; $display("FAIL wb_flag_accept: req_ready=%b required 1", req_ready); end
      writes = 0;
      foreach (exp_q[k]) begin
         checks++;
         if (obs_q[k] !== exp_q[k]) begin
            failures++;
            $display("FAIL wb_flag cycle %0d: got %s required %s", k + 1, fmt(obs_q[k]), fmt(exp_q[k]));
         end
         if (obs_q[k].strb === 1'b1 && obs_q[k].wr === 1'b1) writes++;
      end
      checks++;
      if (writes != (WB_EN ? LB : 0)) begin
         failures++;
         $display("FAIL wb_flag_writes: %0d write strobes required %0d", writes, WB_EN ? LB : 0);
      end
      $display("test_wb_flag: wb_en=%0d write strobes %0d", WB_EN, writes);
   endtask

   task automatic test_random();
      logic [15:0] fa, wa;
      logic        rwb;
      logic [31:0] wd;
      int          bad;
      for (int t = 0; t < 16; t++) begin
         fa  = 16'($urandom);
         rwb = 1'($urandom);
         wa  = ($urandom_range(0, 3) == 0) ? fa : 16'($urandom);
         wd  = $urandom;
         build_expected(fa, rwb, wa, wd);
         run_txn(fa, rwb, wa, wd);
         checks++;
         if (timed_out) begin failures++; $display("FAIL random_accept %0d: req_ready=%b required 1", t, req_ready); end
         bad = 0;
         foreach (exp_q[k]) begin
            checks++;
            if (obs_q[k] !== exp_q[k]) begin
               failures++;
               bad++;
               $display("FAIL random %0d cycle %0d: got %s required %s", t, k + 1, fmt(obs_q[k]), fmt(exp_q[k]));
            end
         end
         $display("test_random %0d: fill=%h wb=%0d wb_addr=%h errors=%0d", t, fa, rwb, wa, bad);
      end
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) ref_mem[i] = i[7:0];
      test_reset();
      test_fill_aligned();
      test_fill_unaligned();
      test_writeback();
      test_reset_mid();
      test_back_to_back();
      test_wb_flag();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
